// File: rtl/sound_pkg.sv
// Shared sound encoding and note constants for the game audio path.
// The game-state FSM imports sound_t from here so both ends agree on selector values.
package sound_pkg;

    typedef enum logic [1:0] {
        UI_PRESS    = 2'd0,
        NEXTLEVEL   = 2'd1,
        CRASH       = 2'd2,
        CELEBRATION = 2'd3
    } sound_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } play_state_t;

    localparam int unsigned MAX_NOTES = 4;
    localparam int unsigned DUR_W     = 6;

    // Note frequencies in Hz.
    localparam int unsigned F_F3 = 175;
    localparam int unsigned F_A3 = 220;
    localparam int unsigned F_C5 = 523;
    localparam int unsigned F_E5 = 659;
    localparam int unsigned F_G5 = 784;
    localparam int unsigned F_C6 = 1047;

    function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned f);
        return clk_hz / (2 * f);
    endfunction

    function automatic logic [1:0] last_note(input sound_t s);
        logic [1:0] n;
        case (s)
            UI_PRESS:  n = 2'd0;
            NEXTLEVEL: n = 2'd2;
            CRASH:     n = 2'd1;
            default:   n = 2'd3;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sound_player_if.sv
// Request/status bundle between the game-state FSM (master) and the sound player (slave).
interface sound_player_if;
    import sound_pkg::*;

    // No valid/ready here: playsound is a level request whose rising edge starts a jingle,
    // soundselector is sampled only in that edge cycle; busy/done report playback status.
    logic        playsound;
    sound_t      soundselector;
    logic        audio_out;
    logic        busy;
    logic        done;
    play_state_t dbg_state;

    modport master (
        output playsound, soundselector,
        input  audio_out, busy, done, dbg_state
    );

    modport slave (
        input  playsound, soundselector,
        output audio_out, busy, done, dbg_state
    );

endinterface

// File: rtl/sound_player_tone_gen.sv
// Free-running square-wave divider: wave toggles every `half` cycles and
// restarts low with a zero count whenever clear is asserted.
module tone_gen #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned HALF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [CNT_W-1:0]  cnt;
    logic [HALF_W-1:0] last_cnt;

    assign last_cnt = half - HALF_W'(1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (HALF_W'(cnt) == last_cnt) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sound_player.sv
// Jingle sequencer: on a playsound rising edge it steps through the selected
// note list, holding each note for its tick count and driving a square wave.
module sound_player
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 12_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic           clk,
    input  logic           reset,
    sound_player_if.slave  bus
);

    localparam int unsigned TICK_CYCLES = CLK_HZ / TICK_HZ;

    localparam int unsigned H_F3 = half_period(CLK_HZ, F_F3);
    localparam int unsigned H_A3 = half_period(CLK_HZ, F_A3);
    localparam int unsigned H_C5 = half_period(CLK_HZ, F_C5);
    localparam int unsigned H_E5 = half_period(CLK_HZ, F_E5);
    localparam int unsigned H_G5 = half_period(CLK_HZ, F_G5);
    localparam int unsigned H_C6 = half_period(CLK_HZ, F_C6);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_HALF =
        max2(max2(max2(H_F3, H_A3), max2(H_C5, H_E5)), max2(H_G5, H_C6));
    localparam int unsigned CNT_W  = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    localparam int unsigned HALF_W = $clog2(MAX_HALF + 1);
    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    // Note ROM: half-period (cycles) and duration (ticks) per sound and note index.
    function automatic int unsigned rom_half_int(input sound_t s, input logic [1:0] i);
        int unsigned h;
        h = H_G5;
        case (s)
            UI_PRESS:  h = H_G5;
            NEXTLEVEL: h = (i == 2'd0) ? H_C5 : (i == 2'd1) ? H_E5 : H_G5;
            CRASH:     h = (i == 2'd0) ? H_A3 : H_F3;
            default:   h = (i == 2'd0) ? H_C5 : (i == 2'd1) ? H_E5 :
                           (i == 2'd2) ? H_G5 : H_C6;
        endcase
        return h;
    endfunction

    function automatic int unsigned rom_dur_int(input sound_t s, input logic [1:0] i);
        int unsigned d;
        d = 5;
        case (s)
            UI_PRESS:  d = 5;
            NEXTLEVEL: d = 8;
            CRASH:     d = (i == 2'd0) ? 15 : 25;
            default:   d = (i == 2'd3) ? 30 : 10;
        endcase
        return d;
    endfunction

    function automatic bit rom_ok();
        bit ok;
        ok = (TICK_CYCLES >= 1);
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < int'(MAX_NOTES); i++) begin
                if (i <= int'(last_note(sound_t'(s[1:0])))) begin
                    ok = ok && (rom_half_int(sound_t'(s[1:0]), i[1:0]) >= 1)
                            && (rom_dur_int(sound_t'(s[1:0]), i[1:0]) >= 1)
                            && (rom_dur_int(sound_t'(s[1:0]), i[1:0]) < (1 << DUR_W));
                end
            end
        end
        return ok;
    endfunction

    if (!rom_ok()) begin : g_rom_check
        $error("sound_player: note ROM contains a zero half-period or an invalid duration");
    end

    play_state_t       state, state_nx;
    logic              playsound_q;
    sound_t            sel_q, sel_nx;
    logic [1:0]        idx_q, idx_nx;
    logic [TICK_W-1:0] tick_q, tick_nx;
    logic [DUR_W-1:0]  dur_q, dur_nx;
    logic              done_q, done_nx;
    logic              tone_clear;
    logic              trigger, tick_end, note_end, last;
    logic [HALF_W-1:0] cur_half;
    logic [DUR_W-1:0]  cur_dur;
    logic              wave;

    assign trigger  = bus.playsound && !playsound_q;
    assign cur_half = HALF_W'(rom_half_int(sel_q, idx_q));
    assign cur_dur  = DUR_W'(rom_dur_int(sel_q, idx_q));
    assign tick_end = (tick_q == TICK_W'(TICK_CYCLES - 1));
    assign note_end = tick_end && (dur_q == cur_dur - DUR_W'(1));
    assign last     = (idx_q == last_note(sel_q));

    always_comb begin
        state_nx   = state;
        sel_nx     = sel_q;
        idx_nx     = idx_q;
        tick_nx    = tick_q;
        dur_nx     = dur_q;
        done_nx    = 1'b0;
        tone_clear = 1'b0;
        // A trigger restarts from note 0 in either state, which also covers preemption.
        if (trigger) begin
            state_nx   = S_PLAY;
            sel_nx     = bus.soundselector;
            idx_nx     = 2'd0;
            tick_nx    = '0;
            dur_nx     = '0;
            tone_clear = 1'b1;
        end else if (state == S_PLAY) begin
            tick_nx = tick_end ? '0 : tick_q + TICK_W'(1);
            if (note_end) begin
                dur_nx     = '0;
                tone_clear = 1'b1;
                if (last) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    idx_nx = idx_q + 2'd1;
                end
            end else if (tick_end) begin
                dur_nx = dur_q + DUR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            playsound_q <= 1'b0;
            sel_q       <= UI_PRESS;
            idx_q       <= 2'd0;
            tick_q      <= '0;
            dur_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            playsound_q <= bus.playsound;
            sel_q       <= sel_nx;
            idx_q       <= idx_nx;
            tick_q      <= tick_nx;
            dur_q       <= dur_nx;
            done_q      <= done_nx;
        end
    end

    tone_gen #(
        .CNT_W  (CNT_W),
        .HALF_W (HALF_W)
    ) u_tone (
        .clk   (clk),
        .reset (reset),
        .clear (tone_clear),
        .half  (cur_half),
        .wave  (wave)
    );

    assign bus.busy      = (state == S_PLAY);
    assign bus.audio_out = (state == S_PLAY) && wave;
    assign bus.done      = done_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: a jingle-level reference model predicts done/busy/audio
// every cycle from the driven requests; a monitor compares against the DUT.
module tb_sound_player;
    import sound_pkg::*;

    localparam int CLK_HZ  = 100_000;
    localparam int TICK_HZ = 100;
    localparam int TC      = CLK_HZ / TICK_HZ;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps;
    logic [1:0] sel;

    sound_player_if bus();

    assign bus.playsound     = ps;
    assign bus.soundselector = sound_t'(sel);

    sound_player #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Jingle tables straight from the musical description: frequency and ticks per note.
    int jf [4][4] = '{'{784, 0, 0, 0}, '{523, 659, 784, 0}, '{220, 175, 0, 0}, '{523, 659, 784, 1047}};
    int jd [4][4] = '{'{5, 0, 0, 0}, '{8, 8, 8, 0}, '{15, 25, 0, 0}, '{10, 10, 10, 30}};
    int jn [4]    = '{1, 3, 2, 4};

    logic [2:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int obs_done = 0;

    // Expected {done, busy, audio} k cycles after the cycle in which sound s was triggered.
    function automatic logic [2:0] exp_at(input int s, input int k);
        int acc;
        acc = 0;
        for (int n = 0; n < jn[s]; n++) begin
            int len;
            int h;
            len = jd[s][n] * TC;
            h   = CLK_HZ / (2 * jf[s][n]);
            if (k < acc + len) return {1'b0, 1'b1, 1'(((k - acc) / h) % 2)};
            acc += len;
        end
        if (k == acc) return 3'b100;
        return 3'b000;
    endfunction

    // Reference model: watches only the bench-driven inputs at each rising edge.
    initial begin
        int m_cyc;
        int m_start;
        int m_sel;
        bit m_active;
        bit m_ps_prev;
        logic [2:0] e;
        m_cyc = 0; m_start = 0; m_sel = 0; m_active = 0; m_ps_prev = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_active = 0;
            end else if (ps && !m_ps_prev) begin
                m_active = 1;
                m_start  = m_cyc;
                m_sel    = int'(sel);
            end
            m_ps_prev = reset ? 1'b0 : ps;
            e = m_active ? exp_at(m_sel, m_cyc - m_start) : 3'b000;
            if (e[2]) exp_done++;
            exp_q.push_back(e);
            m_cyc++;
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the oldest prediction.
    initial begin
        logic [2:0] e;
        logic [2:0] act;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.done, bus.busy, bus.audio_out};
                if (act[2] === 1'b1) obs_done++;
                checks++;
                if (act !== e) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL out cycle=%0d got done/busy/audio=%b expected=%b", cyc, act, e);
                end
                cyc++;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: the next rising edge sees the trigger.
    task automatic start(input int s);
        sel = 2'(s);
        ps  = 1'b1;
        @(negedge clk);
        ps  = 1'b0;
    endtask

    initial begin
        int el;
        int d;
        reset = 1'b1;
        ps    = 1'b0;
        sel   = 2'd0;
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(3);

        // NEXTLEVEL with selector wiggling mid-playback (no trigger).
        start(1);
        el = 0;
        repeat (4) begin
            d = $urandom_range(1000, 5000);
            wait_cycles(d);
            el += d;
            sel = 2'($urandom_range(0, 3));
        end
        wait_cycles(24100 - el);

        // Level-held request plays UI_PRESS exactly once.
        sel = 2'd0;
        ps  = 1'b1;
        wait_cycles(5600);
        ps  = 1'b0;
        wait_cycles(100);

        // CELEBRATION preempted by CRASH, CRASH runs to completion.
        start(3);
        wait_cycles($urandom_range(1500, 2500));
        start(2);
        wait_cycles(40050);

        // Reset mid-CRASH, then reset coinciding with a trigger.
        start(2);
        wait_cycles($urandom_range(300, 900));
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(50);
        sel   = 2'd2;
        ps    = 1'b1;
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        ps    = 1'b0;
        wait_cycles(50);

        // Random back-to-back preemptions.
        repeat (3) begin
            start($urandom_range(0, 3));
            wait_cycles($urandom_range(50, 800));
        end

        // Retrigger in exactly the cycle the UI_PRESS would end naturally.
        start(0);
        wait_cycles(TC * 5 - 1);
        start(0);
        wait_cycles(TC * 5 + 50);

        wait_cycles(3);
        checks++;
        if (obs_done != exp_done) begin
            errors++;
            $display("FAIL done_count got=%0d expected=%0d", obs_done, exp_done);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
